// File: rtl/frame_checker_impl_pkg.sv
// Shared types and constants for the receive-side frame checker.
// Holds the per-port configuration record, the control FSM encoding,
// Ethernet/IPv4 constants, error flag bit positions and the statistics
// bundle that the host register interface reads.
package frame_checker_impl_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4      = 16'h0800;
  localparam int          COUNTER_WIDTH_DEF   = 64;
  localparam int          MIN_FRAME_BYTES_DEF = 60;
  localparam int          MAX_FRAME_BYTES_DEF = 1514;

  localparam int ERR_RUNT     = 0;
  localparam int ERR_OVERSIZE = 1;
  localparam int ERR_NON_IPV4 = 2;
  localparam int ERR_DST      = 3;
  localparam int ERR_USER     = 4;
  localparam int ERR_W        = 5;

  typedef struct packed {
    logic        enable;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
  } port_config_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic [COUNTER_WIDTH_DEF-1:0] rx_frames;
    logic [COUNTER_WIDTH_DEF-1:0] rx_bytes;
    logic [COUNTER_WIDTH_DEF-1:0] good_frames;
    logic [COUNTER_WIDTH_DEF-1:0] bad_frames;
    logic [ERR_W-1:0]             err_flags;
  } rx_stats_t;

endpackage

// File: rtl/frame_checker_impl_if.sv
// Byte-wide AXI-Stream link carrying frames into the checker.
//   data  : stream byte
//   valid : byte valid
//   last  : last byte of frame
//   user  : MAC-reported error, meaningful on the last beat
//   ready : sink ready
interface frame_checker_impl_if;
  logic [7:0] data;
  logic       valid;
  logic       last;
  logic       user;
  logic       ready;

  modport master (output data, valid, last, user, input ready);
  modport slave  (input data, valid, last, user, output ready);
endinterface

// File: rtl/frame_checker_impl_rx_stat_counter.sv
// Saturating statistics counter.
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero the count (wins over en)
//   en       : add inc this cycle
//   inc      : increment amount
//   count    : current value, sticks at all-ones
module rx_stat_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;
  logic [W:0]   sum;

  always_comb begin
    sum     = {1'b0, count_q} + {1'b0, inc};
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (en)
      count_d = sum[W] ? '1 : sum[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/frame_checker_impl.sv
// Receive-side frame checker: AXI-Stream sink that parses Ethernet/IPv4
// headers, classifies each frame as good or bad, and keeps statistics.
//   clk, rst          : clock, synchronous active-high reset
//   start, stop       : measurement control pulses
//   port_config       : enable, expected dst MAC/IP (our src_mac/src_ip)
//   axis_s            : frame stream (slave side)
//   running           : measurement active
//   frame_done        : pulse when a counted frame is classified
//   rx_frames..bad_frames, err_flags : statistics
//
// state    | meaning
// ST_IDLE  | not measuring, frames consumed silently
// ST_RUN   | measuring, frames starting now are counted
// ST_DRAIN | stop seen mid-frame, waiting for that frame to finish
module frame_checker_impl
  import frame_checker_impl_pkg::*;
#(
  parameter int COUNTER_WIDTH   = COUNTER_WIDTH_DEF,
  parameter int MAX_FRAME_BYTES = MAX_FRAME_BYTES_DEF,
  parameter int MIN_FRAME_BYTES = MIN_FRAME_BYTES_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  port_config_t             port_config,
  frame_checker_impl_if.slave      axis_s,
  output logic                     running,
  output logic                     frame_done,
  output logic [COUNTER_WIDTH-1:0] rx_frames,
  output logic [COUNTER_WIDTH-1:0] rx_bytes,
  output logic [COUNTER_WIDTH-1:0] good_frames,
  output logic [COUNTER_WIDTH-1:0] bad_frames,
  output logic [ERR_W-1:0]         err_flags
);

  ctrl_state_e      state_q, state_d;
  logic             ready_q;
  logic [15:0]      idx_q, idx_d;
  logic             in_frame_q, in_frame_d;
  logic             counted_q, counted_d;
  logic [47:0]      dst_mac_q, dst_mac_d;
  logic [15:0]      ethertype_q, ethertype_d;
  logic [3:0]       ver_q, ver_d;
  logic [31:0]      dst_ip_q, dst_ip_d;
  logic             done_q, done_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic             accept, first_beat, start_go, counted_now, cls_fire, cls_good;
  logic [16:0]      len;
  logic [ERR_W-1:0] causes;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    in_frame_d  = in_frame_q;
    counted_d   = counted_q;
    dst_mac_d   = dst_mac_q;
    ethertype_d = ethertype_q;
    ver_d       = ver_q;
    dst_ip_d    = dst_ip_q;
    err_d       = err_q;

    accept      = axis_s.valid & ready_q;
    first_beat  = accept & ~in_frame_q;
    start_go    = start & port_config.enable;
    counted_now = first_beat ? (state_q != ST_IDLE) : counted_q;
    len         = {1'b0, idx_q} + 17'd1;

    if (accept) begin
      case (idx_q)
        16'd0:  dst_mac_d[47:40]  = axis_s.data;
        16'd1:  dst_mac_d[39:32]  = axis_s.data;
        16'd2:  dst_mac_d[31:24]  = axis_s.data;
        16'd3:  dst_mac_d[23:16]  = axis_s.data;
        16'd4:  dst_mac_d[15:8]   = axis_s.data;
        16'd5:  dst_mac_d[7:0]    = axis_s.data;
        16'd12: ethertype_d[15:8] = axis_s.data;
        16'd13: ethertype_d[7:0]  = axis_s.data;
        16'd14: ver_d             = axis_s.data[7:4];
        16'd30: dst_ip_d[31:24]   = axis_s.data;
        16'd31: dst_ip_d[23:16]   = axis_s.data;
        16'd32: dst_ip_d[15:8]    = axis_s.data;
        16'd33: dst_ip_d[7:0]     = axis_s.data;
        default: ;
      endcase
      idx_d      = axis_s.last ? 16'd0 : ((idx_q == 16'hFFFF) ? idx_q : idx_q + 16'd1);
      in_frame_d = ~axis_s.last;
      counted_d  = ~axis_s.last & counted_now;
    end
    // A restart abandons whatever frame is in flight.
    if (start_go)
      counted_d = 1'b0;

    // Classification reads the *_d header copies so the last beat's own byte
    // is included; length gates out fields the frame never carried, since
    // the header registers may still hold a previous frame's values.
    causes               = '0;
    causes[ERR_RUNT]     = len < 17'(MIN_FRAME_BYTES);
    causes[ERR_OVERSIZE] = len > 17'(MAX_FRAME_BYTES);
    causes[ERR_NON_IPV4] = (len < 17'd15) | (ethertype_d != ETHERTYPE_IPV4) | (ver_d != 4'h4);
    causes[ERR_DST]      = (len < 17'd34) | (dst_mac_d != port_config.src_mac) |
                           (dst_ip_d != port_config.src_ip);
    causes[ERR_USER]     = axis_s.user;
    cls_good             = (causes == '0);
    cls_fire             = accept & axis_s.last & counted_now & ~start_go;
    done_d               = cls_fire;

    if (start_go)
      err_d = '0;
    else if (cls_fire)
      err_d = err_q | causes;

    case (state_q)
      ST_IDLE: if (start_go) state_d = ST_RUN;
      ST_RUN: begin
        if (start_go)
          state_d = ST_RUN;
        else if (stop)
          state_d = ((in_frame_q | accept) & ~(accept & axis_s.last)) ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (start_go)
          state_d = ST_RUN;
        else if (accept & axis_s.last)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      idx_q       <= '0;
      in_frame_q  <= 1'b0;
      counted_q   <= 1'b0;
      dst_mac_q   <= '0;
      ethertype_q <= '0;
      ver_q       <= '0;
      dst_ip_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= 1'b1;
      idx_q       <= idx_d;
      in_frame_q  <= in_frame_d;
      counted_q   <= counted_d;
      dst_mac_q   <= dst_mac_d;
      ethertype_q <= ethertype_d;
      ver_q       <= ver_d;
      dst_ip_q    <= dst_ip_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign axis_s.ready = ready_q;
  assign running      = (state_q != ST_IDLE);
  assign frame_done   = done_q;
  assign err_flags    = err_q;

  rx_stat_counter #(.W(COUNTER_WIDTH)) u_rx_frames (
    .clk(clk), .rst(rst), .clr(start_go), .en(cls_fire),
    .inc(COUNTER_WIDTH'(1)), .count(rx_frames));

  rx_stat_counter #(.W(COUNTER_WIDTH)) u_rx_bytes (
    .clk(clk), .rst(rst), .clr(start_go), .en(cls_fire),
    .inc(COUNTER_WIDTH'(len)), .count(rx_bytes));

  rx_stat_counter #(.W(COUNTER_WIDTH)) u_good_frames (
    .clk(clk), .rst(rst), .clr(start_go), .en(cls_fire & cls_good),
    .inc(COUNTER_WIDTH'(1)), .count(good_frames));

  rx_stat_counter #(.W(COUNTER_WIDTH)) u_bad_frames (
    .clk(clk), .rst(rst), .clr(start_go), .en(cls_fire & ~cls_good),
    .inc(COUNTER_WIDTH'(1)), .count(bad_frames));

endmodule

// File: tb/tb_frame_checker_impl.sv
module tb_frame_checker_impl;
  import frame_checker_impl_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  port_config_t cfg;
  logic         running, frame_done;
  logic [63:0]  rx_frames, rx_bytes, good_frames, bad_frames;
  logic [4:0]   err_flags;

  frame_checker_impl_if axis_s();

  frame_checker_impl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .port_config(cfg),
    .axis_s(axis_s), .running(running), .frame_done(frame_done),
    .rx_frames(rx_frames), .rx_bytes(rx_bytes), .good_frames(good_frames),
    .bad_frames(bad_frames), .err_flags(err_flags));

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int done_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model (frame-level) ----------------
  int          m_state = 0;          // 0 idle, 1 run, 2 drain
  logic        m_ready = 1'b0, m_done = 1'b0;
  logic [63:0] m_frames = '0, m_bytes = '0, m_good = '0, m_bad = '0;
  logic [4:0]  m_err = '0;
  logic        m_in_frame = 1'b0, m_counted = 1'b0;
  int          m_len = 0;
  logic [7:0]  m_fb [0:2047];
  bit          m_started = 1'b0;

  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[64] ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
  endfunction

  function automatic logic [4:0] classify(input int len, input logic user);
    logic [4:0]  c;
    logic [47:0] mac;
    logic [31:0] ip;
    logic [15:0] et;
    c    = '0;
    c[0] = len < 60;
    c[1] = len > 1514;
    et   = {m_fb[12], m_fb[13]};
    c[2] = !(len >= 15 && et == 16'h0800 && m_fb[14][7:4] == 4'h4);
    mac  = {m_fb[0], m_fb[1], m_fb[2], m_fb[3], m_fb[4], m_fb[5]};
    ip   = {m_fb[30], m_fb[31], m_fb[32], m_fb[33]};
    c[3] = !(len >= 34 && mac == cfg.src_mac && ip == cfg.src_ip);
    c[4] = user;
    return c;
  endfunction

  always @(posedge clk) begin : model
    logic       acc, go, cn;
    logic [4:0] c;
    int         old;
    m_started = 1'b1;
    if (rst) begin
      m_state = 0; m_ready = 1'b0; m_done = 1'b0;
      m_frames = '0; m_bytes = '0; m_good = '0; m_bad = '0; m_err = '0;
      m_in_frame = 1'b0; m_counted = 1'b0; m_len = 0;
    end else begin
      acc     = axis_s.valid && m_ready;
      m_ready = 1'b1;
      go      = start && cfg.enable;
      m_done  = 1'b0;
      old     = m_state;
      if (acc) begin
        cn = !m_in_frame ? (old != 0) : m_counted;
        if (m_len < 2048) m_fb[m_len] = axis_s.data;
        m_len++;
        if (axis_s.last) begin
          if (cn && !go) begin
            c        = classify(m_len, axis_s.user);
            m_frames = sat_add(m_frames, 64'd1);
            m_bytes  = sat_add(m_bytes, 64'(m_len));
            if (c == 0) m_good = sat_add(m_good, 64'd1);
            else        m_bad  = sat_add(m_bad, 64'd1);
            m_err  = m_err | c;
            m_done = 1'b1;
          end
          m_len = 0; m_in_frame = 1'b0; m_counted = 1'b0;
        end else begin
          m_in_frame = 1'b1; m_counted = cn;
        end
      end
      if (go) begin
        m_counted = 1'b0;
        m_frames = '0; m_bytes = '0; m_good = '0; m_bad = '0; m_err = '0;
        m_state = 1;
      end else if (old == 1 && stop) begin
        m_state = m_in_frame ? 2 : 0;
      end else if (old == 2 && acc && axis_s.last) begin
        m_state = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("ready",       64'(axis_s.ready), 64'(m_ready));
      chk("running",     64'(running), 64'(m_state != 0));
      chk("frame_done",  64'(frame_done), 64'(m_done));
      chk("rx_frames",   rx_frames, m_frames);
      chk("rx_bytes",    rx_bytes, m_bytes);
      chk("good_frames", good_frames, m_good);
      chk("bad_frames",  bad_frames, m_bad);
      chk("err_flags",   64'(err_flags), 64'(m_err));
      if (frame_done) done_seen++;
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0]  fbuf[$];
  logic [47:0] MAC = 48'h02_00_00_00_00_01;
  logic [31:0] IP  = 32'hC0_A8_00_01;

  task automatic idle(input int n);
    axis_s.valid = 1'b0; axis_s.last = 1'b0; axis_s.user = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    axis_s.valid = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    axis_s.valid = 1'b0; stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  task automatic build(input int len, input logic [47:0] mac, input logic [31:0] ip,
                       input logic [15:0] et, input logic [3:0] ver);
    logic [7:0] b;
    fbuf.delete();
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      if (i <= 5)                b = mac[8*(5-i) +: 8];
      else if (i == 12)          b = et[15:8];
      else if (i == 13)          b = et[7:0];
      else if (i == 14)          b = {ver, 4'h5};
      else if (i >= 30 && i <= 33) b = ip[8*(33-i) +: 8];
      fbuf.push_back(b);
    end
  endtask

  task automatic send(input logic user, input int stop_at, input int start_at,
                      input int rst_at, input int gap_pct);
    int n;
    n = fbuf.size();
    for (int i = 0; i < n; i++) begin
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        axis_s.valid = 1'b0; stop = 1'b0; start = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
      end
      axis_s.valid = 1'b1;
      axis_s.data  = fbuf[i];
      axis_s.last  = (i == n - 1);
      axis_s.user  = (i == n - 1) ? user : 1'($urandom);
      stop  = (i == stop_at);
      start = (i == start_at);
      rst   = (i == rst_at);
      @(posedge clk); #1;
    end
    axis_s.valid = 1'b0; axis_s.last = 1'b0; axis_s.user = 1'b0;
    stop = 1'b0; start = 1'b0; rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    cfg = '{enable: 1'b1, src_mac: MAC, src_ip: IP};
    axis_s.valid = 1'b0; axis_s.data = '0; axis_s.last = 1'b0; axis_s.user = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(axis_s.ready), 64'd0);
    chk("rst_running", 64'(running), 64'd0);
    chk("rst_frames", rx_frames, 64'd0);
    rst = 1'b0;
    idle(2);
    chk("ready_up", 64'(axis_s.ready), 64'd1);

    // one good 100-byte frame
    pulse_start();
    chk("run_after_start", 64'(running), 64'd1);
    done_seen = 0;
    build(100, MAC, IP, 16'h0800, 4'h4); send(1'b0, -1, -1, -1, 0);
    idle(2);
    chk("t1_frames", rx_frames, 64'd1);
    chk("t1_bytes", rx_bytes, 64'd100);
    chk("t1_good", good_frames, 64'd1);
    chk("t1_bad", bad_frames, 64'd0);
    chk("t1_err", 64'(err_flags), 64'd0);
    chk("t1_done_pulses", 64'(done_seen), 64'd1);

    // runt, oversize, non-IPv4
    pulse_start();
    build(40, MAC, IP, 16'h0800, 4'h4);   send(1'b0, -1, -1, -1, 10);
    build(1600, MAC, IP, 16'h0800, 4'h4); send(1'b0, -1, -1, -1, 0);
    build(100, MAC, IP, 16'h86DD, 4'h4);  send(1'b0, -1, -1, -1, 0);
    idle(2);
    chk("t2_bad", bad_frames, 64'd3);
    chk("t2_good", good_frames, 64'd0);
    chk("t2_err", 64'(err_flags), 64'b00111);
    chk("t2_bytes", rx_bytes, 64'd1740);

    // ten back-to-back frames
    pulse_start();
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      build(64, MAC, IP, 16'h0800, 4'h4); send(1'b0, -1, -1, -1, 0);
    end
    idle(2);
    chk("t3_good", good_frames, 64'd10);
    chk("t3_bytes", rx_bytes, 64'd640);
    chk("t3_done_pulses", 64'(done_seen), 64'd10);

    // stop mid-frame
    pulse_start();
    build(100, MAC, IP, 16'h0800, 4'h4); send(1'b0, 50, -1, -1, 0);
    chk("t4_running_dropped", 64'(running), 64'd0);
    chk("t4_frames", rx_frames, 64'd1);
    build(100, MAC, IP, 16'h0800, 4'h4); send(1'b0, -1, -1, -1, 0);
    idle(2);
    chk("t4_frames_after", rx_frames, 64'd1);
    chk("t4_bytes_after", rx_bytes, 64'd100);

    // user error, then dst IP off by one
    pulse_start();
    build(100, MAC, IP, 16'h0800, 4'h4);         send(1'b1, -1, -1, -1, 0);
    build(100, MAC, IP + 32'd1, 16'h0800, 4'h4); send(1'b0, -1, -1, -1, 0);
    idle(2);
    chk("t5_bad", bad_frames, 64'd2);
    chk("t5_err", 64'(err_flags), 64'b11000);

    // reset mid-frame
    pulse_start();
    build(100, MAC, IP, 16'h0800, 4'h4); send(1'b0, -1, -1, 50, 0);
    idle(3);
    chk("t6_running_rst", 64'(running), 64'd0);
    chk("t6_frames_rst", rx_frames, 64'd0);
    pulse_start();
    build(100, MAC, IP, 16'h0800, 4'h4); send(1'b0, -1, -1, -1, 0);
    idle(2);
    chk("t6_frames", rx_frames, 64'd1);
    chk("t6_bytes", rx_bytes, 64'd100);
    chk("t6_good", good_frames, 64'd1);
    chk("t6_bad", bad_frames, 64'd0);

    // single-beat frame
    pulse_start();
    build(1, MAC, IP, 16'h0800, 4'h4); send(1'b0, -1, -1, -1, 0);
    idle(2);
    chk("t7_bad", bad_frames, 64'd1);
    chk("t7_bytes", rx_bytes, 64'd1);
    chk("t7_runt_dst", 64'(err_flags & 5'b01001), 64'b01001);

    // stop while idle-in-run, then start with enable low is ignored
    pulse_stop();
    chk("t8_stopped", 64'(running), 64'd0);
    cfg.enable = 1'b0;
    pulse_start();
    chk("t8_start_ignored", 64'(running), 64'd0);
    cfg.enable = 1'b1;

    // randomized traffic against the model
    pulse_start();
    for (int k = 0; k < 40; k++) begin
      int          len, r, stop_at, start_at;
      logic [47:0] mac;
      logic [31:0] ip;
      logic [15:0] et;
      logic [3:0]  ver;
      r = int'($urandom_range(9));
      if (r == 0)      len = int'($urandom_range(59, 1));
      else if (r == 1) len = int'($urandom_range(1530, 1500));
      else             len = int'($urandom_range(300, 60));
      mac = ($urandom_range(9) < 8) ? cfg.src_mac : cfg.src_mac ^ (48'd1 << $urandom_range(47));
      ip  = ($urandom_range(9) < 8) ? cfg.src_ip  : cfg.src_ip  ^ (32'd1 << $urandom_range(31));
      et  = ($urandom_range(9) < 9) ? 16'h0800 : 16'(16'h0806);
      ver = ($urandom_range(9) < 9) ? 4'h4 : 4'h6;
      stop_at  = ($urandom_range(19) == 0) ? int'($urandom_range(len - 1)) : -1;
      start_at = ($urandom_range(19) == 0) ? int'($urandom_range(len - 1)) : -1;
      build(len, mac, ip, et, ver);
      send(1'($urandom_range(9) == 0), stop_at, start_at, -1, ($urandom_range(1) == 1) ? 20 : 0);
      if ($urandom_range(9) == 0) cfg.src_ip = 32'($urandom);
      if (m_state == 0 && $urandom_range(1) == 1) pulse_start();
      if ($urandom_range(3) == 0) idle(int'($urandom_range(3, 1)));
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/frame_checker_impl.md
Name: frame_checker_impl

Overview:
- Receive-side counterpart of the frame generator: an AXI-Stream sink on the tester port that receives test frames back from the device under test.
- Parses the Ethernet/IPv4 header of each frame and classifies the frame as good or bad.
- Keeps per-port frame/byte/good/bad counters that the host reads out after a measurement.
- Sits directly downstream of the port RX path and beside the frame generator, sharing its start/stop/port_config controls.

Parameters:
- COUNTER_WIDTH, 64, width of every statistics counter.
- MAX_FRAME_BYTES, 1514, largest legal frame length excluding FCS.
- MIN_FRAME_BYTES, 60, smallest legal frame length excluding FCS.

Ports:
- clk  in  1  port clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse: clear counters, begin measuring
- stop  in  1  one-cycle pulse: end measuring at next frame boundary
- port_config  in  port_config_t  per-port config (enable, src_mac, src_ip, ...)
- axis_s_data  in  8  stream byte
- axis_s_valid  in  1  byte valid
- axis_s_last  in  1  last byte of frame
- axis_s_user  in  1  MAC-reported error, sampled on the last beat
- axis_s_ready  out  1  sink ready
- running  out  1  measurement active
- frame_done  out  1  one-cycle pulse when a counted frame is classified
- rx_frames, rx_bytes, good_frames, bad_frames  out  COUNTER_WIDTH each  statistics
- err_flags  out  5  sticky error causes: [0] runt, [1] oversize, [2] non-IPv4, [3] dst mismatch, [4] user error

Behaviour:
- Reset values: all outputs 0, axis_s_ready 0, FSM in IDLE.
- Ready: axis_s_ready is 1 in every cycle after reset, with no backpressure. A beat is accepted when valid and ready are both 1.
- Control FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start with port_config.enable=1. This clears all counters and err_flags in the same edge.
  - start with enable=0 is ignored.
  - RUN -> DRAIN on stop when a frame is in progress.
  - RUN -> IDLE on stop when no frame is in progress.
  - DRAIN -> IDLE after the in-progress frame's classification cycle. That frame is counted.
  - start while in RUN or DRAIN restarts the measurement: counters clear and the state becomes RUN. A frame already in progress at that point is not counted.
  - running = 1 in RUN and DRAIN.
- Frame tracking:
  - A 16-bit byte index, saturating at 0xFFFF, resets to 0 after the last beat.
  - in_frame is set on the first accepted beat and cleared after the last beat.
  - A frame is counted only if its first beat was accepted while running=1. Frames that start in IDLE are consumed silently.
- Header capture, by byte index:
  - bytes 0-5: dst MAC
  - bytes 12-13: EtherType
  - byte 14: version/IHL
  - bytes 30-33: IPv4 dst address
- Classification is evaluated on the last beat using length = index+1:
  - runt: length < MIN_FRAME_BYTES
  - oversize: length > MAX_FRAME_BYTES
  - non-IPv4: EtherType != 0x0800 or version nibble != 4
  - dst mismatch: dst MAC != port_config.src_mac or dst IP != port_config.src_ip. Header fields not yet received count as mismatch.
  - user error: axis_s_user=1 on the last beat
  - good = none of the above.
- Latency: counters, err_flags and frame_done update exactly 1 cycle after the last-beat acceptance.
  - rx_frames += 1
  - rx_bytes += length
  - good_frames or bad_frames += 1
  - err_flags |= causes
- Counters saturate at all-ones and never wrap.
- Back-to-back frames (last beat followed immediately by a first beat) must be handled with no gap cycle.
- Single-beat frame (first beat = last beat): length 1, flagged runt and dst mismatch.
- Reset mid-frame: the partial frame is discarded. After reset, the first accepted beat is treated as byte 0 of a new frame.
- port_config is sampled combinationally at classification. Changing it mid-run is allowed; the value in effect at the last beat applies.

Decomposition:
- The shared package (tester_common) gains:
  - constants ETHERTYPE_IPV4, MIN_FRAME_BYTES and MAX_FRAME_BYTES default values
  - err_flags bit index constants
  - rx_stats_t struct bundling the four counters and err_flags, for the host register interface.
- One natural sub-module, rx_stat_counter: a saturating counter with clear, enable and variable increment, instantiated four times.

Test Plan:
- Start pulse, then one 100-byte IPv4 frame whose dst MAC/IP equal port_config.src_mac/src_ip -> one cycle after last: rx_frames=1, rx_bytes=100, good_frames=1, bad_frames=0, err_flags=0, frame_done pulses once.
- A 40-byte frame, then a 1600-byte frame, then a 100-byte frame with EtherType 0x86DD -> bad_frames=3, good_frames=0, err_flags=5'b00111, rx_bytes=1740.
- Ten back-to-back 64-byte good frames with valid held high -> good_frames=10, rx_bytes=640, ten frame_done pulses.
- Stop asserted at byte 50 of a 100-byte frame -> frame still counted (rx_frames=1); running drops the cycle after classification. A frame sent afterwards leaves the counters unchanged.
- Good frame with axis_s_user=1 on last beat, then a frame with dst IP off by 1 -> bad_frames=2, err_flags=5'b11000.
- Reset asserted mid-frame, then start, then a good 100-byte frame -> counters are exactly 1/100/1/0.
